// File: rtl/sr_drive_ctrl.sv
// Debounces two raw pushbuttons into clean one-cycle s/r pulses for an SR flip-flop, never s=r=1.
// Latency: button high at edge 1 -> pulse between edges 3+D and 4+D; no backpressure, min pulse spacing 2 cycles.
module sr_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_btn,
  input  logic             clr_btn,
  output logic             s,
  output logic             r,
  output logic             exp_q,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    LOCK    = 2'd3
  } state_e;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Bit 0 tracks the set button, bit 1 the clear button.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      rise;

  state_e          state_q, state_d;
  logic            pend_s_q, pend_s_d;
  logic            pend_r_q, pend_r_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            exp_q_q, exp_q_d;
  logic            conflict_q, conflict_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic            busy_q, busy_d;

  always_comb begin
    sync1_d = {clr_btn, set_btn};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      // Level must disagree for DEBOUNCE_CYCLES consecutive samples before it is accepted.
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
    rise = deb_d & ~deb_q;

    state_d        = state_q;
    pend_s_d       = pend_s_q;
    pend_r_d       = pend_r_q;
    exp_q_d        = exp_q_q;
    conflict_d     = 1'b0;
    conflict_cnt_d = conflict_cnt_q;

    case (state_q)
      IDLE: begin
        if (&deb_q) begin
          state_d    = LOCK;
          pend_s_d   = 1'b0;
          pend_r_d   = 1'b0;
          conflict_d = 1'b1;
          if (conflict_cnt_q != {CNT_W{1'b1}}) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
          end
        end else if (pend_s_q) begin
          state_d  = PULSE_S;
          pend_s_d = 1'b0;
          exp_q_d  = 1'b1;
        end else if (pend_r_q) begin
          state_d  = PULSE_R;
          pend_r_d = 1'b0;
          exp_q_d  = 1'b0;
        end
      end
      PULSE_S, PULSE_R: state_d = IDLE;
      LOCK: begin
        // Anything latched while locked is stale once both buttons are released.
        if (~|deb_q) begin
          state_d  = IDLE;
          pend_s_d = 1'b0;
          pend_r_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh press is never lost, even on an edge that clears pendings.
    if (rise[0]) pend_s_d = 1'b1;
    if (rise[1]) pend_r_d = 1'b1;

    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE) | pend_s_d | pend_r_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      cnt_q          <= '0;
      state_q        <= IDLE;
      pend_s_q       <= 1'b0;
      pend_r_q       <= 1'b0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      exp_q_q        <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
      busy_q         <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      pend_s_q       <= pend_s_d;
      pend_r_q       <= pend_r_d;
      s_q            <= s_d;
      r_q            <= r_d;
      exp_q_q        <= exp_q_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
      busy_q         <= busy_d;
    end
  end

  assign s            = s_q;
  assign r            = r_q;
  assign exp_q        = exp_q_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = conflict_cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_sr_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_btn = 1'b0;
  logic       clr_btn = 1'b0;
  logic       s, r, exp_q, conflict, busy;
  logic [7:0] conflict_cnt;
  logic       s2, r2, exp_q2, conflict2, busy2;
  logic [1:0] conflict_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s), .r(r), .exp_q(exp_q), .conflict(conflict),
    .conflict_cnt(conflict_cnt), .busy(busy)
  );

  sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s2), .r(r2), .exp_q(exp_q2), .conflict(conflict2),
    .conflict_cnt(conflict_cnt2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_btn = 1'b0;
    clr_btn = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_exp_q", 32'(exp_q), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Set held from edge 1: s only between edges 7 and 8
    set_btn = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("set_s_e%0d", e), 32'(s), 32'(e == 7));
      chk($sformatf("set_r_e%0d", e), 32'(r), 32'd0);
      chk($sformatf("set_expq_e%0d", e), 32'(exp_q), 32'(e >= 7));
      chk($sformatf("set_busy_e%0d", e), 32'(busy), 32'(e == 6 || e == 7));
    end
    set_btn = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("release_noreq_e%0d", e), 32'({s, r, busy}), 32'd0);
    end

    // Glitch of 3 synchronized samples: nothing happens
    do_reset();
    set_btn = 1'b1;
    repeat (3) tick();
    set_btn = 1'b0;
    for (int e = 4; e <= 16; e++) begin
      tick();
      chk($sformatf("glitch_s_busy_e%0d", e), 32'({s, busy}), 32'd0);
      chk($sformatf("glitch_expq_e%0d", e), 32'(exp_q), 32'd0);
    end

    // Set press (6 samples) then clear press 10 cycles later
    do_reset();
    set_btn = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 6) set_btn = 1'b0;
      if (e == 10) clr_btn = 1'b1;
      chk($sformatf("sr_s_e%0d", e), 32'(s), 32'(e == 7));
      chk($sformatf("sr_r_e%0d", e), 32'(r), 32'(e == 17));
      chk($sformatf("sr_expq_e%0d", e), 32'(exp_q), 32'(e >= 7 && e < 17));
      chk($sformatf("sr_excl_e%0d", e), 32'(s & r), 32'd0);
    end
    clr_btn = 1'b0;
    repeat (12) tick();

    // Both buttons together: LOCK, one conflict, no pulses
    do_reset();
    set_btn = 1'b1;
    clr_btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 10) begin
        set_btn = 1'b0;
        clr_btn = 1'b0;
      end
      chk($sformatf("lock_sr_e%0d", e), 32'({s, r}), 32'd0);
      chk($sformatf("lock_conflict_e%0d", e), 32'(conflict), 32'(e == 7));
      chk($sformatf("lock_cnt_e%0d", e), 32'(conflict_cnt), 32'(e >= 7 ? 1 : 0));
      chk($sformatf("lock_busy_e%0d", e), 32'(busy), 32'(e >= 6 && e < 17));
    end
    chk("lock_cnt2_1", 32'(conflict_cnt2), 32'd1);

    // Four more conflicts: narrow counter saturates at 3
    for (int k = 2; k <= 5; k++) begin
      set_btn = 1'b1;
      clr_btn = 1'b1;
      repeat (10) tick();
      chk($sformatf("sat_cnt2_%0d", k), 32'(conflict_cnt2), 32'(k > 3 ? 3 : k));
      chk($sformatf("sat_cnt8_%0d", k), 32'(conflict_cnt), 32'(k));
      chk($sformatf("sat_sr_%0d", k), 32'({s, r, s2, r2}), 32'd0);
      set_btn = 1'b0;
      clr_btn = 1'b0;
      repeat (10) tick();
      chk($sformatf("sat_idle_busy_%0d", k), 32'(busy), 32'd0);
    end

    // Reset asserted mid-pulse between edges
    do_reset();
    set_btn = 1'b1;
    repeat (7) tick();
    chk("midrst_s_before", 32'(s), 32'd1);
    chk("midrst_expq_before", 32'(exp_q), 32'd1);
    #2;
    rst = 1'b1;
    set_btn = 1'b0;
    #1;
    chk("midrst_s_async", 32'(s), 32'd0);
    chk("midrst_expq_async", 32'(exp_q), 32'd0);
    chk("midrst_busy_async", 32'(busy), 32'd0);
    tick();
    #2;
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk($sformatf("postrst_quiet_e%0d", e), 32'({s, r, exp_q, busy}), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Upstream command stage for the SR flip-flop. It converts two raw pushbutton inputs (set, clear) into clean one-cycle `s`/`r` pulses. It guarantees that the illegal `s=r=1` combination never reaches the flip-flop. It also tracks the state the flip-flop is expected to hold and counts conflicting requests.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples needed to accept a button level change; legal range 2..255.
- CNT_W, 8: width of the conflict counter.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- set_btn  in  1  raw asynchronous set button, active-high.
- clr_btn  in  1  raw asynchronous clear button, active-high.
- s  out  1  set pulse to the SR flip-flop.
- r  out  1  reset pulse to the SR flip-flop.
- exp_q  out  1  expected flip-flop state after the issued pulse is applied.
- conflict  out  1  one-cycle pulse when both buttons are held simultaneously.
- conflict_cnt  out  CNT_W  saturating count of conflict events.
- busy  out  1  high when the FSM is not in IDLE, or when any request is pending.

## Operation

- Synchronizer: each button passes through two flops (sync1, sync2).
- Debouncer, per button:
  - Keeps a debounced level `deb` and a counter.
  - While sync2 != deb, the counter increments each edge. When it reaches DEBOUNCE_CYCLES, deb takes the new value and the counter clears.
  - Any sample with sync2 == deb clears the counter.
- Request latch:
  - A 0→1 transition of deb sets `pend_s` or `pend_r` on the same edge.
  - A 1→0 transition generates no request.
- FSM states: IDLE, PULSE_S, PULSE_R, LOCK.
  - IDLE → LOCK if both deb levels are 1. Clears both pendings, pulses `conflict`, increments conflict_cnt.
  - IDLE → PULSE_S, else if pend_s is set. Clears pend_s and sets exp_q=1. Set has priority over clear.
  - IDLE → PULSE_R, else if pend_r is set. Clears pend_r and sets exp_q=0.
  - PULSE_S / PULSE_R → IDLE unconditionally after one cycle.
  - LOCK → IDLE only when both deb levels are 0. Rising edges latched during LOCK are discarded on exit.
- Outputs:
  - `s` = (state==PULSE_S) and `r` = (state==PULSE_R), both registered. `s&r` is never 1.
  - Outside a pulse, s=r=0, so the flip-flop holds.
- conflict_cnt saturates at 2^CNT_W−1 and never wraps.
- A request arriving during PULSE_x stays pending and is served on the next IDLE cycle.

## Timing

- Reset values: s=0, r=0, exp_q=0, conflict=0, conflict_cnt=0, busy=0. State is IDLE; all sync, deb, counter and pending bits are 0.
- Reset asserted mid-operation clears everything immediately, including an in-flight s/r pulse. After release, the first edge behaves as a post-reset edge.
- Latency, counting from the first rising edge at which a raw button is sampled high (edge 1) and stays stable:
  - sync2=1 at edge 2.
  - deb=1 and pend set at edge 2+D.
  - FSM enters PULSE at edge 3+D.
  - s or r is high for exactly the cycle between edges 3+D and 4+D.
- With D=4, s is high between edges 7 and 8, and the flip-flop captures it at edge 8.
- exp_q updates at the same edge the FSM enters PULSE_x.
- conflict is high for exactly one cycle, on the cycle the FSM enters LOCK.
- A glitch shorter than D consecutive synchronized samples produces no pulse.
- Minimum spacing between two pulses is 2 cycles (PULSE, IDLE).

## Test plan

- Reset, then set_btn held high from edge 1 with D=4 → s=1 only between edges 7 and 8, r=0 throughout, exp_q=1 from edge 7, busy=0 from edge 8.
- set_btn high for 3 synchronized samples, then low (D=4) → no s pulse, exp_q stays 0, deb never changes.
- Set press, then clr_btn press 10 cycles later → one s pulse, then one r pulse 10 cycles after it, exp_q 0→1→0, s and r never high in the same cycle.
- Both buttons rise on the same edge → FSM goes to LOCK, conflict pulses once, conflict_cnt=1, no s/r pulse. Releasing both → IDLE with no pulse.
- CNT_W=2 with 5 conflict events → conflict_cnt reads 1, 2, 3, 3, 3.
- rst asserted during PULSE_S, between a clock edge and the next → s drops to 0 immediately and exp_q=0. After release with buttons low, no pulse occurs.
